fpio_xmit_fifo: RTL and testbench

Register-programmed, FIFO-buffered parallel transmitter for the fpio block family. It generalises the single-register transmit path with a parametrised data width, a FIFO of configurable depth, a programmable bit-rate divisor, level-threshold interrupts, and overflow/underrun status. It sits between the host register bus and the `dat_o` pins, and instantiates no sub-blocks.

---
 rtl/fpio_xmit_fifo.sv | 165 ++++++++++++++++
 tb/tb_fpio_xmit_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpio_xmit_fifo.sv
// fpio_xmit_fifo: register-programmed FIFO-buffered parallel transmitter.
// Optional underrun detection: define FPIO_XMIT_UNDERRUN_EN.
module fpio_xmit_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            addr,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  dat_strb_o,
  output logic                  irq
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [PW:0]           count;
  logic [7:0]            level;
  logic                  empty;
  logic                  full;

  logic                  en_q;
  logic                  irq_en_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  cnt_q;
  logic [7:0]            thresh_q;
  logic                  ovf_q;
  logic                  udr_q;

  logic                  wr_ctrl;
  logic                  wr_div;
  logic                  wr_stat;
  logic                  wr_thr;
  logic                  push_req;
  logic                  flush;
  logic                  tick;
  logic                  pop;
  logic                  push;
  logic [31:0]           rd_mux;
  logic                  unused_wdata;

  assign unused_wdata = &{1'b0, wdata};

  assign count = wr_ptr - rd_ptr;
  assign level = 8'(count);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign wr_ctrl  = write_en && (addr == 3'd0);
  assign wr_div   = write_en && (addr == 3'd1);
  assign wr_stat  = write_en && (addr == 3'd2);
  assign wr_thr   = write_en && (addr == 3'd3);
  assign push_req = write_en && (addr == 3'd4);

  assign flush = wr_ctrl && wdata[1];
  assign tick  = en_q && (cnt_q == '0);
  // flush beats a same-cycle pop; a pop frees room for a push when full
  assign pop   = tick && !empty && !flush;
  assign push  = push_req && (!full || pop);

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= '0;
      thresh_q <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= wdata[0];
        irq_en_q <= wdata[2];
      end
      if (wr_div) div_q <= wdata[DIV_WIDTH-1:0];
      if (wr_thr) thresh_q <= wdata[7:0];
    end
  end

  // bit-rate divisor: parked at DIV while idle, reloads after each tick
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (!en_q || cnt_q == '0) cnt_q <= div_q;
    else cnt_q <= cnt_q - 1'b1;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= wdata[DATA_WIDTH-1:0];
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // output word and strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_o      <= '0;
      dat_strb_o <= 1'b0;
    end else begin
      dat_strb_o <= pop;
      if (pop) dat_o <= mem[rd_ptr[PW-1:0]];
    end
  end

  // sticky overflow, write-1-clear
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (push_req && full && !pop) ovf_q <= 1'b1;
    else if (wr_stat && wdata[10]) ovf_q <= 1'b0;
  end

`ifdef FPIO_XMIT_UNDERRUN_EN
  // sticky underrun, write-1-clear; a new underrun wins over the clear
  always_ff @(posedge clk) begin
    if (rst) udr_q <= 1'b0;
    else if (tick && empty) udr_q <= 1'b1;
    else if (wr_stat && wdata[11]) udr_q <= 1'b0;
  end
`else
  assign udr_q = 1'b0;
`endif

  // read mux
  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0: rd_mux[2:0] = {irq_en_q, 1'b0, en_q};
      3'd1: rd_mux[DIV_WIDTH-1:0] = div_q;
      3'd2: rd_mux[11:0] = {udr_q, ovf_q, full, empty, level};
      3'd3: rd_mux[7:0] = thresh_q;
      default: rd_mux = '0;
    endcase
  end

  // registered read data, held between reads
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (read_en) rdata <= rd_mux;
  end

  // level interrupt
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else irq <= irq_en_q && ((level <= thresh_q) || ovf_q || udr_q);
  end

endmodule

// File: tb/tb_fpio_xmit_fifo.sv
// tb_fpio_xmit_fifo: directed bench for fpio_xmit_fifo.
// Register table plus hand sequences for timing corners.
module tb_fpio_xmit_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  dat_o;
  logic        dat_strb_o;
  logic        irq;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int sc[$];
  logic [3:0] sv[$];

`ifdef FPIO_XMIT_UNDERRUN_EN
  localparam logic [31:0] UDR = 32'h800;
`else
  localparam logic [31:0] UDR = 32'h000;
`endif

  fpio_xmit_fifo dut (
    .clk(clk), .rst(rst), .addr(addr),
    .write_en(write_en), .read_en(read_en),
    .wdata(wdata), .rdata(rdata),
    .dat_o(dat_o), .dat_strb_o(dat_strb_o),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dat_strb_o) begin
      sc.push_back(cyc);
      sv.push_back(dat_o);
    end
  end

  typedef struct {
    bit          is_rd;
    logic [2:0]  a;
    logic [31:0] d;
    string       nm;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, act, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a;
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    d = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_strb(input string nm, input int s0,
                          input int idx, input int t0,
                          input int exp_dt, input logic [3:0] exp_v);
    int dt;
    logic [3:0] v;
    dt = -1;
    v = 'x;
    if (s0 + idx < sc.size()) begin
      dt = sc[s0 + idx] - t0;
      v = sv[s0 + idx];
    end
    chk({nm, "_t"}, dt, exp_dt);
    chk({nm, "_v"}, {28'b0, v}, {28'b0, exp_v});
  endtask

  initial begin
    logic [31:0] r;
    int s0;
    int t0;

    tbl[0]  = '{1'b0, 3'd1, 32'd3,         "div_wr"};
    tbl[1]  = '{1'b1, 3'd1, 32'd3,         "div_rd"};
    tbl[2]  = '{1'b0, 3'd3, 32'h1AB,       "thr_wr"};
    tbl[3]  = '{1'b1, 3'd3, 32'hAB,        "thr_rd"};
    tbl[4]  = '{1'b0, 3'd0, 32'h2,         "flush_wr"};
    tbl[5]  = '{1'b1, 3'd0, 32'h0,         "ctrl_rd"};
    tbl[6]  = '{1'b0, 3'd5, 32'hFFFF_FFFF, "bad_wr"};
    tbl[7]  = '{1'b1, 3'd5, 32'h0,         "bad_rd"};
    tbl[8]  = '{1'b1, 3'd4, 32'h0,         "data_rd"};
    tbl[9]  = '{1'b0, 3'd4, 32'h1,         "push1"};
    tbl[10] = '{1'b0, 3'd4, 32'h2,         "push2"};
    tbl[11] = '{1'b0, 3'd4, 32'h13,        "push3"};
    tbl[12] = '{1'b1, 3'd2, 32'h003,       "stat_lvl3"};
    tbl[13] = '{1'b1, 3'd7, 32'h0,         "addr7_rd"};

    idle(3);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dat", {28'b0, dat_o}, 32'h0);
    chk("rst_strb", {31'b0, dat_strb_o}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    rd(3'd2, r);
    chk("rst_status", r, 32'h100);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_rd) begin
        rd(tbl[i].a, r);
        chk(tbl[i].nm, r, tbl[i].d);
      end else begin
        wr(tbl[i].a, tbl[i].d);
      end
    end

    // DIV=3 stream of 1,2,3 then underrun
    s0 = sc.size();
    t0 = cyc;
    wr(3'd0, 32'h1);
    idle(20);
    chk("strm_cnt", sc.size() - s0, 32'd3);
    for (int i = 0; i < 3; i++)
      chk_strb("strm", s0, i, t0, 5 + 4 * i, 4'(i + 1));
    chk("udr_hold", {28'b0, dat_o}, 32'h3);
    wr(3'd0, 32'h0);
    rd(3'd2, r);
    chk("udr_stat", r, 32'h100 | UDR);
    wr(3'd2, 32'hC00);
    rd(3'd2, r);
    chk("udr_clr", r, 32'h100);

    // overflow
    for (int i = 0; i < 9; i++) wr(3'd4, 32'(i));
    rd(3'd2, r);
    chk("ovf_stat", r, 32'h608);
    wr(3'd2, 32'h400);
    rd(3'd2, r);
    chk("ovf_clr", r, 32'h208);

    // threshold interrupt
    wr(3'd0, 32'h2);
    rd(3'd2, r);
    chk("flush_empty", r, 32'h100);
    for (int i = 0; i < 4; i++) wr(3'd4, 32'(5 + i));
    wr(3'd3, 32'h2);
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h5);
    chk("irq_lvl4", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_lvl4b", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_lvl3", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_lvl2", {31'b0, irq}, 32'h1);
    wr(3'd0, 32'h0);
    wr(3'd2, 32'hC00);

    // push into full FIFO on a pop cycle
    for (int i = 1; i <= 8; i++) wr(3'd4, 32'(i));
    rd(3'd2, r);
    chk("full8", r, 32'h208);
    s0 = sc.size();
    wr(3'd0, 32'h1);
    wr(3'd4, 32'h9);
    wr(3'd0, 32'h0);
    rd(3'd2, r);
    chk("fullpush_stat", r, 32'h007);
    chk("fullpush_cnt", sc.size() - s0, 32'd2);
    if (sc.size() - s0 >= 2) begin
      chk("fullpush_v0", {28'b0, sv[s0]}, 32'h1);
      chk("fullpush_v1", {28'b0, sv[s0 + 1]}, 32'h2);
    end

    // flush mid-stream, beating the same-cycle pop
    s0 = sc.size();
    t0 = cyc;
    wr(3'd0, 32'h1);
    idle(1);
    wr(3'd0, 32'h3);
    idle(8);
    chk("flush_cnt", sc.size() - s0, 32'd1);
    chk_strb("flush", s0, 0, t0, 2, 4'h3);
    wr(3'd0, 32'h0);
    rd(3'd2, r);
    chk("flush_stat", r, 32'h100 | UDR);
    chk("flush_hold", {28'b0, dat_o}, 32'h3);

    // reset mid-transfer
    wr(3'd2, 32'hC00);
    wr(3'd3, 32'h10);
    wr(3'd4, 32'h5);
    wr(3'd4, 32'h6);
    wr(3'd0, 32'h5);
    idle(2);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    chk("pre_rst_dat", {28'b0, dat_o}, 32'h6);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_dat", {28'b0, dat_o}, 32'h0);
    chk("mid_rst_strb", {31'b0, dat_strb_o}, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    rd(3'd2, r);
    chk("post_rst_stat", r, 32'h100);
    rd(3'd0, r);
    chk("post_rst_ctrl", r, 32'h0);
    rd(3'd1, r);
    chk("post_rst_div", r, 32'h0);
    rd(3'd3, r);
    chk("post_rst_thr", r, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
